// File: rtl/sram_pkg.sv
// Constants and types shared by the SRAM read and write paths.
// Rail levels and the sense margin are in volts.
package sram_pkg;

  localparam real VDD     = 1.5;
  localparam real VSS     = 0.0;
  localparam real VTH     = 0.8;
  localparam real VMARGIN = 0.1;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    EVAL,
    SENSE,
    DONE
  } rd_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_sense_amp.sv
// Single-column sense comparator: resolves a bitline pair to a rail level.
// Flags the column when the differential is inside the margin band.
module sram_sense_amp
  import sram_pkg::*;
(
  input  real  bl,
  input  real  blb,
  output real  level,
  output logic marginal
);

  real diff;

  assign diff     = bl - blb;
  // A marginal pair resolves to VSS, so a weak cell can never read back as a 1.
  assign level    = (diff >= VMARGIN) ? VDD : VSS;
  assign marginal = (diff < VMARGIN) && (diff > -VMARGIN);

endmodule

// File: rtl/sram_read_sense.sv
// Read-path sequencer (precharge, evaluate, one sense strobe) with
// per-column capture of the resolved bitline levels.
module sram_read_sense
  import sram_pkg::*;
#(
  parameter int COLS     = 8,
  parameter int PRE_CYC  = 2,
  parameter int EVAL_CYC = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic rd_req,
  input  real  bl_rd    [0:COLS-1],
  input  real  blb_rd   [0:COLS-1],
  output logic pre_en,
  output logic wl_en,
  output logic sae,
  output logic busy,
  output real  data_out [0:COLS-1],
  output logic rd_valid,
  output logic rd_err
);

  localparam int CNT_W = $clog2(max_int(PRE_CYC, EVAL_CYC) + 1);

  rd_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pre_nxt, wl_nxt, sae_nxt, busy_nxt, valid_nxt;

  real              sensed   [0:COLS-1];
  logic [COLS-1:0]  marginal;

  for (genvar i = 0; i < COLS; i++) begin : g_col
    sram_sense_amp u_sense_amp (
      .bl       (bl_rd[i]),
      .blb      (blb_rd[i]),
      .level    (sensed[i]),
      .marginal (marginal[i])
    );
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: if (rd_req) begin
        state_nxt = PRE;
        cnt_nxt   = CNT_W'(PRE_CYC - 1);
      end
      PRE: if (cnt == '0) begin
        state_nxt = EVAL;
        cnt_nxt   = CNT_W'(EVAL_CYC - 1);
      end else begin
        cnt_nxt = cnt - 1'b1;
      end
      EVAL: if (cnt == '0) state_nxt = SENSE;
            else           cnt_nxt   = cnt - 1'b1;
      SENSE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Outputs are decoded from the next state and registered alongside it.
    pre_nxt   = (state_nxt == PRE);
    wl_nxt    = (state_nxt == EVAL) || (state_nxt == SENSE);
    sae_nxt   = (state_nxt == SENSE);
    valid_nxt = (state_nxt == DONE);
    busy_nxt  = (state_nxt != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      pre_en   <= 1'b0;
      wl_en    <= 1'b0;
      sae      <= 1'b0;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      pre_en   <= pre_nxt;
      wl_en    <= wl_nxt;
      sae      <= sae_nxt;
      busy     <= busy_nxt;
      rd_valid <= valid_nxt;
    end
  end

  // NOTE: the capture array is explicitly reset, so read data is a defined VSS after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < COLS; i++) data_out[i] <= VSS;
      rd_err <= 1'b0;
    end else if (state == SENSE) begin
      for (int i = 0; i < COLS; i++) data_out[i] <= sensed[i];
      rd_err <= |marginal;
    end
  end

endmodule

// File: tb/tb_sram_read_sense.sv
// Directed bench for sram_read_sense: a cycle-table timing model plus a
// scoreboard of expected read data popped on every rd_valid.
module tb_sram_read_sense;
  import sram_pkg::*;

  localparam int COLS = 8;
  localparam int P    = 2;
  localparam int E    = 3;
  localparam int LAT  = P + E + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd_req = 1'b0;
  real  bl_rd    [0:COLS-1];
  real  blb_rd   [0:COLS-1];
  real  data_out [0:COLS-1];
  logic pre_en, wl_en, sae, busy, rd_valid, rd_err;

  sram_read_sense #(.COLS(COLS), .PRE_CYC(P), .EVAL_CYC(E)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_req   (rd_req),
    .bl_rd    (bl_rd),
    .blb_rd   (blb_rd),
    .pre_en   (pre_en),
    .wl_en    (wl_en),
    .sae      (sae),
    .busy     (busy),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .rd_err   (rd_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected read results: {rd_err, column bits}, bit i set means data_out[i] = VDD.
  logic [COLS:0] exp_q [$];
  logic [COLS:0] held = '0;
  int            t = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h want 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: control outputs against the cycle table, data against the scoreboard.
  logic [4:0] exp_ctl;
  int         bad_col;
  always @(negedge clk) begin
    exp_ctl = {(t >= 1 && t <= P), (t >= P + 1 && t <= P + E + 1), (t == P + E + 1),
               (t != 0), (t == LAT)};
    check("ctrl{pre,wl,sae,busy,valid}", {27'd0, pre_en, wl_en, sae, busy, rd_valid},
          {27'd0, exp_ctl});

    if (rd_valid) begin
      if (exp_q.size() == 0) check("rd_valid_unexpected", 32'd1, 32'd0);
      else held = exp_q.pop_front();
    end

    n_cmp++;
    bad_col = -1;
    for (int i = 0; i < COLS; i++)
      if (data_out[i] != (held[i] ? VDD : VSS)) bad_col = i;
    if (bad_col >= 0) begin
      n_err++;
      $display("FAIL data_out[%0d] @%0t: got %f want %f", bad_col, $time,
               data_out[bad_col], held[bad_col] ? VDD : VSS);
    end
    check("rd_err", {31'd0, rd_err}, {31'd0, held[COLS]});

    // Advance the model to what the next rising edge will produce.
    if (rst) begin
      t    = 0;
      held = '0;
      exp_q.delete();
    end else if (t == 0) begin
      t = rd_req ? 1 : 0;
    end else if (t == LAT) begin
      t = 0;
    end else begin
      t++;
    end
  end

  task automatic set_pattern(input logic [COLS-1:0] bits);
    for (int i = 0; i < COLS; i++) begin
      bl_rd[i]  = bits[i] ? VDD : VSS;
      blb_rd[i] = bits[i] ? VSS : VDD;
    end
  endtask

  task automatic do_read(input logic [COLS:0] exp);
    @(posedge clk); #1 rd_req = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk); #1 rd_req = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
  endtask

  // Bitlines wrong during PRE/EVAL, right only around SENSE, marginal afterwards;
  // a stray rd_req pulse lands while busy.
  task automatic do_read_scrambled(input logic [COLS-1:0] bits);
    @(posedge clk); #1 rd_req = 1'b1;
    exp_q.push_back({1'b0, bits});
    set_pattern(~bits);
    @(posedge clk); #1 rd_req = 1'b0;
    @(posedge clk); #1 rd_req = 1'b1;
    @(posedge clk); #1 rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 set_pattern(bits);
    repeat (2) @(posedge clk);
    #1 for (int i = 0; i < COLS; i++) begin
      bl_rd[i]  = 0.8;
      blb_rd[i] = 0.8;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    set_pattern('0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Even columns high, odd low.
    set_pattern(8'h55);
    do_read({1'b0, 8'h55});

    // Columns 2 and 3 inside the margin band (+/-0.05 V): both VSS, error flagged.
    set_pattern(8'h55);
    bl_rd[3] = 0.80; blb_rd[3] = 0.75;
    bl_rd[2] = 0.75; blb_rd[2] = 0.80;
    do_read({1'b1, 8'h51});

    // Clean read clears the error flag.
    set_pattern(8'hAA);
    do_read({1'b0, 8'hAA});

    // Differential exactly at +VMARGIN and -VMARGIN resolves without a flag.
    set_pattern(8'hAA);
    bl_rd[0] = 0.1; blb_rd[0] = 0.0;
    bl_rd[1] = 0.0; blb_rd[1] = 0.1;
    do_read({1'b0, 8'hA9});

    // rd_req held high: one accept every P+E+3 cycles.
    set_pattern(8'h3C);
    @(posedge clk); #1 rd_req = 1'b1;
    repeat (3) exp_q.push_back({1'b0, 8'h3C});
    repeat (3 * (P + E + 3)) @(posedge clk);
    #1 rd_req = 1'b0;
    repeat (3) @(posedge clk);

    // Reset in the middle of EVAL aborts the read.
    set_pattern(8'hF0);
    @(posedge clk); #1 rd_req = 1'b1;
    exp_q.push_back({1'b0, 8'hF0});
    @(posedge clk); #1 rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    set_pattern(8'h0F);
    do_read({1'b0, 8'h0F});

    do_read_scrambled(8'hC3);
    repeat (4) @(posedge clk);
    #1;

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_read_sense.md
# sram_read_sense

Read-path controller and sense stage for the mixed-signal SRAM array; the read-side counterpart of the column write driver. On a read request it sequences bitline precharge, wordline evaluation and a single sense strobe, then resolves each column's real-valued bitline pair (bl/blb) into a rail-level data value using the same convention as the write path (bit 1 ⇔ bl high, blb low). It sits between the row/column array and the digital read-data consumer, and owns the read-phase enables driven into the array.

## Interface
Parameters:
- COLS, 8, number of columns sensed in parallel
- PRE_CYC, 2, precharge phase length in cycles (≥1)
- EVAL_CYC, 3, wordline evaluation length in cycles before the sense strobe (≥1)

Ports:
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- rd_req  input  1  read request; accepted only when busy=0
- bl_rd  input  real [0:COLS-1]  bitline voltages from the array
- blb_rd  input  real [0:COLS-1]  complementary bitline voltages
- pre_en  output  1  bitline precharge enable
- wl_en  output  1  wordline enable for the selected row
- sae  output  1  sense-amplifier enable strobe
- busy  output  1  high whenever state ≠ IDLE
- data_out  output  real [0:COLS-1]  sensed data, rail levels VDD/VSS, held until next capture
- rd_valid  output  1  one-cycle pulse: data_out/rd_err updated
- rd_err  output  1  at least one column sensed with insufficient differential

## Operation
- FSM states: IDLE, PRE, EVAL, SENSE, DONE. All control outputs registered, decoded from state.
- IDLE: all enables 0. rd_req=1 → PRE, phase counter loaded.
- PRE: pre_en=1 for exactly PRE_CYC cycles → EVAL.
- EVAL: wl_en=1 for exactly EVAL_CYC cycles → SENSE.
- SENSE: wl_en=1, sae=1 for one cycle; at its closing edge each column is resolved and captured, rd_err captured → DONE.
- DONE: rd_valid=1 for one cycle, all enables 0 → IDLE.
- Column resolution, diff = bl_rd[i] − blb_rd[i]: diff ≥ VMARGIN → VDD; diff ≤ −VMARGIN → VSS; |diff| < VMARGIN → VSS and column flagged. rd_err = OR of flags.
- pre_en, wl_en, sae mutually exclusive except wl_en+sae in SENSE; pre_en never overlaps wl_en.
- rd_req while busy=1: ignored, not queued. rd_req held high in DONE: not accepted until IDLE (one idle cycle minimum between reads).
- Bitline inputs only sampled at SENSE capture; values in other phases have no effect.

## Timing
- Reset (any state, including mid-read): state IDLE, counter 0, pre_en=wl_en=sae=busy=rd_valid=rd_err=0, every data_out[i]=VSS (0.0). Aborted read produces no rd_valid.
- Accept at edge k (IDLE, rd_req=1): pre_en high cycles k+1…k+PRE_CYC; wl_en high k+PRE_CYC+1…k+PRE_CYC+EVAL_CYC+1; sae high cycle k+PRE_CYC+EVAL_CYC+1; rd_valid high cycle k+PRE_CYC+EVAL_CYC+2.
- Latency accept-edge → rd_valid = PRE_CYC+EVAL_CYC+2 cycles (7 at defaults); back-to-back read period = PRE_CYC+EVAL_CYC+3 cycles.
- busy high from cycle k+1 through the rd_valid cycle inclusive.
- data_out and rd_err change only at the SENSE closing edge or reset.

## Structure
- Shared package sram_pkg: VDD=1.5, VSS=0.0, VTH=0.8, VMARGIN=0.1 (real constants, shared with write path); read FSM state enum.
- Phase counter width sized from max(PRE_CYC, EVAL_CYC).
- Natural sub-module: sram_sense_amp, one per column via generate — combinational real comparator producing resolved level and marginal flag; capture registers stay in sram_read_sense.

## Test plan
- Reset then idle: all outputs 0, data_out all 0.0; raise rd_req → pre_en exactly 2 cycles, wl_en 4 cycles, sae 1 cycle, rd_valid at accept+7.
- bl_rd=1.5/blb_rd=0.0 on even columns, reverse on odd → data_out = {1.5,0.0,1.5,…}, rd_err=0.
- Column 3 bl=0.80/blb=0.75 (diff 0.05), others clean → data_out[3]=0.0, rd_err=1; next clean read clears rd_err to 0.
- rd_req held high continuously → reads accepted every 8 cycles, rd_valid pulses one cycle each, no overlap of pre_en with wl_en.
- rst asserted during EVAL → next cycle all outputs 0, data_out all 0.0, no rd_valid; new rd_req after release runs full sequence.
- Bitlines changed during PRE/EVAL then stable at SENSE, and changed after SENSE → only SENSE-cycle values appear in data_out, held through following idle cycles.
